// File: rtl/axi_dma_pkg.sv
// Shared definitions for the AXI4 block-copy DMA.
//   dma_state_e      : copy controller states
//   AXI_* constants  : burst type and response encodings
//   calc_blen()      : beats in the next burst, limited by the remaining count,
//                      the burst cap and both 4 KiB page boundaries
package axi_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_ADDR = 3'd3,
    ST_WR_DATA = 3'd4,
    ST_WR_RESP = 3'd5,
    ST_FINISH  = 3'd6
  } dma_state_e;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Addresses are beat aligned, so the room left in a 4 KiB page is always at
  // least one beat and the result is never zero while rem is non-zero.
  function automatic logic [8:0] calc_blen(input logic [11:0]  src_off,
                                           input logic [11:0]  dst_off,
                                           input logic [31:0]  rem,
                                           input int unsigned  max_burst,
                                           input int unsigned  beat_sh);
    logic [31:0] n;
    logic [31:0] room;
    n = rem;
    if (max_burst < n) n = max_burst;
    room = (32'd4096 - {20'd0, src_off}) >> beat_sh;
    if (room < n) n = room;
    room = (32'd4096 - {20'd0, dst_off}) >> beat_sh;
    if (room < n) n = room;
    return 9'(n);
  endfunction

endpackage

// File: rtl/dma_sync_fifo.sv
// Single-clock beat buffer between the read and write phases of a burst.
//   clk_i, rst_i (async, active-low)
//   push_i/data_i : write one entry (ignored when full)
//   pop_i/data_o  : data_o is the head entry; pop_i removes it (ignored when empty)
//   full_o, empty_o
module dma_sync_fifo #(
  parameter int DATA_WTH = 256,
  parameter int DEPTH    = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic [DATA_WTH-1:0] data_i,
  input  logic                pop_i,
  output logic [DATA_WTH-1:0] data_o,
  output logic                full_o,
  output logic                empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]       wptr_q, rptr_q;
  logic [CW-1:0]       cnt_q;
  logic                do_push, do_pop;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rptr_q];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/axi_dma_copy.sv
// AXI4 block-copy initiator: moves beats_i beats from src_addr_i to dst_addr_i
// as alternating INCR read and write bursts through a local beat buffer.
//   clk_i, rst_i (async, active-low)
//   start_i, src_addr_i, dst_addr_i, beats_i : copy request (accepted in IDLE)
//   busy_o, done_o (1-cycle pulse), err_o (sticky until the next start)
//   aw*/w*/b*/ar*/r* : AXI4 master port
module axi_dma_copy
  import axi_dma_pkg::*;
#(
  parameter int                ADDR_WTH   = 32,
  parameter int                DATA_WTH   = 256,
  parameter int                ID_WIDTH   = 4,
  parameter logic [ID_WIDTH-1:0] DMA_ID   = '0,
  parameter int                MAX_BURST  = 16,
  parameter int                FIFO_DEPTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WTH-1:0]   src_addr_i,
  input  logic [ADDR_WTH-1:0]   dst_addr_i,
  input  logic [31:0]           beats_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  // write address
  output logic [ID_WIDTH-1:0]   awid,
  output logic [ADDR_WTH-1:0]   awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic [3:0]            awqos,
  output logic [3:0]            awregion,
  output logic                  awvalid,
  input  logic                  awready,
  // write data
  output logic [DATA_WTH-1:0]   wdata,
  output logic [DATA_WTH/8-1:0] wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  // write response
  input  logic [ID_WIDTH-1:0]   bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  // read address
  output logic [ID_WIDTH-1:0]   arid,
  output logic [ADDR_WTH-1:0]   araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic [3:0]            arqos,
  output logic [3:0]            arregion,
  output logic                  arvalid,
  input  logic                  arready,
  // read data
  input  logic [ID_WIDTH-1:0]   rid,
  input  logic [DATA_WTH-1:0]   rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready
);

  localparam int          BEAT_B = DATA_WTH / 8;
  localparam int          BEAT_SH = $clog2(BEAT_B);
  localparam logic [2:0]  AXSIZE = 3'(BEAT_SH);

  dma_state_e          state_q, state_d;
  logic [ADDR_WTH-1:0] src_q, src_d, dst_q, dst_d;
  logic [31:0]         rem_q, rem_d;
  logic [8:0]          blen_q, blen_d;
  logic [8:0]          cnt_q, cnt_d;
  logic [7:0]          len_q, len_d;
  logic                err_q, err_d;
  logic                load_burst;
  logic [ADDR_WTH-1:0] step;

  logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [DATA_WTH-1:0] fifo_head;
  logic                unused_ids;

  assign unused_ids = ^{rid, bid};

  dma_sync_fifo #(.DATA_WTH(DATA_WTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (rdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // All handshake outputs decode from registered state, so an asynchronous
  // reset drops them immediately.
  assign arvalid = (state_q == ST_RD_ADDR);
  assign rready  = (state_q == ST_RD_DATA) && !fifo_full;
  assign awvalid = (state_q == ST_WR_ADDR);
  assign wvalid  = (state_q == ST_WR_DATA) && !fifo_empty;
  assign wlast   = (state_q == ST_WR_DATA) && (cnt_q == blen_q - 9'd1);
  assign bready  = (state_q == ST_WR_RESP);
  assign wdata   = fifo_head;
  assign wstrb   = '1;

  assign fifo_push = rvalid && rready;
  assign fifo_pop  = wvalid && wready;

  assign araddr = src_q;
  assign awaddr = dst_q;
  assign arlen  = len_q;
  assign awlen  = len_q;

  assign arid = DMA_ID;     assign awid = DMA_ID;
  assign arsize = AXSIZE;   assign awsize = AXSIZE;
  assign arburst = AXI_BURST_INCR; assign awburst = AXI_BURST_INCR;
  assign arlock = 1'b0;     assign awlock = 1'b0;
  assign arcache = '0;      assign awcache = '0;
  assign arprot = '0;       assign awprot = '0;
  assign arqos = '0;        assign awqos = '0;
  assign arregion = '0;     assign awregion = '0;

  assign busy_o = (state_q != ST_IDLE) && (state_q != ST_FINISH);
  assign done_o = (state_q == ST_FINISH);
  assign err_o  = err_q;

  assign step = ADDR_WTH'(blen_q) << BEAT_SH;

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    rem_d      = rem_q;
    blen_d     = blen_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    err_d      = err_q;
    load_burst = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          src_d = src_addr_i;
          dst_d = dst_addr_i;
          rem_d = beats_i;
          err_d = 1'b0;
          if (beats_i == 32'd0) begin
            state_d = ST_FINISH;
          end else begin
            state_d    = ST_RD_ADDR;
            load_burst = 1'b1;
          end
        end
      end
      ST_RD_ADDR: begin
        if (arready) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (fifo_push) begin
          cnt_d = cnt_q + 9'd1;
          if (rresp != AXI_RESP_OKAY) err_d = 1'b1;
          if (rlast) begin
            // A burst that ends early or late is flagged but not aborted.
            if (cnt_q + 9'd1 != blen_q) err_d = 1'b1;
            state_d = ST_WR_ADDR;
          end
        end
      end
      ST_WR_ADDR: begin
        if (awready) begin
          state_d = ST_WR_DATA;
          cnt_d   = '0;
        end
      end
      ST_WR_DATA: begin
        if (fifo_pop) begin
          cnt_d = cnt_q + 9'd1;
          if (wlast) state_d = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (bvalid) begin
          if (bresp != AXI_RESP_OKAY) err_d = 1'b1;
          src_d = src_q + step;
          dst_d = dst_q + step;
          rem_d = rem_q - 32'(blen_q);
          if (rem_d == 32'd0) begin
            state_d = ST_FINISH;
          end else begin
            state_d    = ST_RD_ADDR;
            load_burst = 1'b1;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    // Burst length is fixed on entry to RD_ADDR from the updated addresses.
    if (load_burst) begin
      blen_d = calc_blen(src_d[11:0], dst_d[11:0], rem_d, MAX_BURST, BEAT_SH);
      len_d  = 8'(blen_d - 9'd1);
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      blen_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      blen_q  <= blen_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_dma_copy.sv
module tb_axi_dma_copy;
  import axi_dma_pkg::*;

  localparam int AW = 32;
  localparam int DW = 256;
  localparam int IW = 4;
  localparam int BB = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start_i = 1'b0;
  logic [AW-1:0] src_addr_i = '0, dst_addr_i = '0;
  logic [31:0]   beats_i = '0;
  logic          busy_o, done_o, err_o;
  logic [IW-1:0] awid, arid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize, awprot, arprot;
  logic [1:0]    awburst, arburst;
  logic          awlock, arlock;
  logic [3:0]    awcache, arcache, awqos, arqos, awregion, arregion;
  logic          awvalid, wvalid, wlast, bready, arvalid, rready;
  logic [DW-1:0] wdata;
  logic [BB-1:0] wstrb;
  logic          awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0;
  logic          rvalid = 1'b0, rlast = 1'b0;
  logic [1:0]    bresp = 2'b00, rresp = 2'b00;
  logic [IW-1:0] bid = '0, rid = '0;
  logic [DW-1:0] rdata = '0;

  axi_dma_copy dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .beats_i(beats_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos),
    .awregion(awregion), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arqos(arqos),
    .arregion(arregion), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: unwritten beats read back a pattern derived from the address.
  logic [DW-1:0] mem [int unsigned];

  function automatic logic [DW-1:0] pat(input logic [31:0] a);
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[32*i +: 32] = a ^ (32'(i) << 24) ^ 32'h5A5A_0000;
    return r;
  endfunction

  function automatic logic [DW-1:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a >> 5)) return mem[a >> 5];
    return pat(a);
  endfunction

  bit          thr = 1'b0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  int          done_cnt = 0;
  logic [31:0] ar_addr_log[$], aw_addr_log[$];
  int          ar_len_log[$], aw_len_log[$], wb_len_log[$];

  // Responder: samples handshakes at the falling edge (values the DUT sees at
  // the next rising edge), then updates and drives just after that rising edge.
  initial begin : responder
    int r_left, w_cnt, cyc;
    logic [31:0] r_addr, w_addr;
    bit w_act, b_pend, gate;
    bit s_ar, s_r, s_aw, s_w, s_b;
    logic [31:0] s_araddr, s_awaddr;
    logic [7:0] s_arlen, s_awlen;
    logic [DW-1:0] s_wdata;
    logic s_wlast;
    bit p_rst, p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
    logic [31:0] p_araddr, p_awaddr;
    logic [7:0] p_arlen, p_awlen;
    logic [DW-1:0] p_wdata;
    logic p_wlast;
    r_left = 0; w_cnt = 0; cyc = 0; r_addr = '0; w_addr = '0;
    w_act = 0; b_pend = 0; p_rst = 0; p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0;
    p_wv = 0; p_wr = 0; p_araddr = '0; p_awaddr = '0; p_arlen = '0; p_awlen = '0;
    p_wdata = '0; p_wlast = 0;
    forever begin
      @(negedge clk);
      if (done_o) done_cnt++;
      if (rst_n && p_rst) begin
        if (p_arv && !p_arr) chk("ar_hold", {arvalid, araddr == p_araddr, arlen == p_arlen}, 3'b111);
        if (p_awv && !p_awr) chk("aw_hold", {awvalid, awaddr == p_awaddr, awlen == p_awlen}, 3'b111);
        if (p_wv && !p_wr)   chk("w_hold", {wvalid, wdata == p_wdata, wlast == p_wlast}, 3'b111);
      end
      s_ar = arvalid && arready; s_araddr = araddr; s_arlen = arlen;
      s_r  = rvalid && rready;
      s_aw = awvalid && awready; s_awaddr = awaddr; s_awlen = awlen;
      s_w  = wvalid && wready; s_wdata = wdata; s_wlast = wlast;
      s_b  = bvalid && bready;
      if (s_ar) chk("ar_fields", {arid, arburst, arsize, arcache, arprot, arqos, arregion, arlock},
                    {4'd0, 2'b01, 3'd5, 4'd0, 3'd0, 4'd0, 4'd0, 1'b0});
      if (s_aw) chk("aw_fields", {awid, awburst, awsize, awcache, awprot, awqos, awregion, awlock},
                    {4'd0, 2'b01, 3'd5, 4'd0, 3'd0, 4'd0, 4'd0, 1'b0});
      if (s_w) chk("wstrb", wstrb, 32'hFFFF_FFFF);
      p_rst = rst_n; p_arv = arvalid; p_arr = arready; p_araddr = araddr; p_arlen = arlen;
      p_awv = awvalid; p_awr = awready; p_awaddr = awaddr; p_awlen = awlen;
      p_wv = wvalid; p_wr = wready; p_wdata = wdata; p_wlast = wlast;

      @(posedge clk);
      #1;
      if (!rst_n) begin
        r_left = 0; w_act = 0; b_pend = 0;
        arready = 0; rvalid = 0; rlast = 0; awready = 0; wready = 0; bvalid = 0;
        continue;
      end
      cyc++;
      gate = !thr || (cyc % 4 == 0);
      // read side
      if (s_ar) begin
        ar_addr_log.push_back(s_araddr);
        ar_len_log.push_back(int'(s_arlen));
        r_addr = s_araddr;
        r_left = int'(s_arlen) + 1;
      end
      if (s_r) begin
        r_left--;
        r_addr += BB;
      end
      if (!(rvalid && !s_r)) begin
        if (r_left > 0 && gate) begin
          rvalid = 1; rdata = mem_rd(r_addr); rlast = (r_left == 1);
          rresp = (r_addr == err_addr) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        end else begin
          rvalid = 0; rlast = 0; rresp = AXI_RESP_OKAY;
        end
      end
      arready = gate && (r_left == 0);
      // write side
      if (s_aw) begin
        aw_addr_log.push_back(s_awaddr);
        aw_len_log.push_back(int'(s_awlen));
        w_addr = s_awaddr; w_cnt = 0; w_act = 1;
      end
      if (s_w) begin
        mem[w_addr >> 5] = s_wdata;
        w_addr += BB;
        w_cnt++;
        if (s_wlast) begin
          wb_len_log.push_back(w_cnt);
          w_act = 0; b_pend = 1;
        end
      end
      if (!(bvalid && !s_b)) begin
        if (b_pend && gate) begin
          bvalid = 1; bresp = AXI_RESP_OKAY; b_pend = 0;
        end else begin
          bvalid = 0;
        end
      end
      awready = gate && !w_act && !b_pend && !bvalid;
      wready  = gate && w_act;
    end
  end

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] beats;
    bit          thr;
    logic [31:0] err_addr;
    int          nb;
    int          l0;
    int          l1;
    int          l2;
    bit          exp_err;
  } vec_t;

  task automatic run_vec(input string tag, input vec_t v);
    int arb, awb, wlb, dbase, k, cum, mism;
    int lens[3];
    thr = v.thr;
    err_addr = v.err_addr;
    arb = ar_addr_log.size(); awb = aw_addr_log.size(); wlb = wb_len_log.size();
    dbase = done_cnt;
    @(posedge clk); #1;
    src_addr_i = v.src; dst_addr_i = v.dst; beats_i = v.beats; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk({tag, "_err_cleared"}, err_o, 1'b0);
    if (v.beats != 0) chk({tag, "_busy_arvalid"}, {busy_o, arvalid}, 2'b11);
    for (k = 0; k < 3000; k++) begin
      if (done_o) break;
      @(posedge clk); #1;
    end
    chk({tag, "_done_seen"}, done_o, 1'b1);
    if (v.beats == 0) chk({tag, "_zero_latency"}, k, 0);
    chk({tag, "_busy_at_done"}, busy_o, 1'b0);
    chk({tag, "_err_at_done"}, err_o, v.exp_err);
    repeat (3) begin @(posedge clk); #1; end
    chk({tag, "_done_pulses"}, done_cnt - dbase, 1);
    chk({tag, "_err_held"}, err_o, v.exp_err);
    chk({tag, "_ar_count"}, ar_addr_log.size() - arb, v.nb);
    chk({tag, "_aw_count"}, aw_addr_log.size() - awb, v.nb);
    chk({tag, "_wburst_count"}, wb_len_log.size() - wlb, v.nb);
    lens = '{v.l0, v.l1, v.l2};
    cum = 0;
    for (int i = 0; i < v.nb; i++) begin
      if (arb + i < ar_addr_log.size() && awb + i < aw_addr_log.size() && wlb + i < wb_len_log.size()) begin
        chk({tag, "_arlen"}, ar_len_log[arb+i], lens[i] - 1);
        chk({tag, "_awlen"}, aw_len_log[awb+i], lens[i] - 1);
        chk({tag, "_wlast_pos"}, wb_len_log[wlb+i], lens[i]);
        chk({tag, "_araddr"}, ar_addr_log[arb+i], v.src + 32'(cum * BB));
        chk({tag, "_awaddr"}, aw_addr_log[awb+i], v.dst + 32'(cum * BB));
      end
      cum += lens[i];
    end
    mism = 0;
    for (int i = 0; i < int'(v.beats); i++) begin
      if (!mem.exists((v.dst + 32'(i * BB)) >> 5)) mism++;
      else if (mem[(v.dst + 32'(i * BB)) >> 5] != pat(v.src + 32'(i * BB))) mism++;
    end
    chk({tag, "_data_mismatches"}, mism, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t vecs[6];
    vec_t post;
    int k;
    vecs[0] = '{32'h8000_1000, 32'h8000_2000, 32'd4,  1'b0, 32'hFFFF_FFFF, 1, 4,  0,  0, 1'b0};
    vecs[1] = '{32'h8001_0000, 32'h8002_0000, 32'd40, 1'b0, 32'hFFFF_FFFF, 3, 16, 16, 8, 1'b0};
    vecs[2] = '{32'h8000_0FC0, 32'h8000_3000, 32'd4,  1'b0, 32'hFFFF_FFFF, 2, 2,  2,  0, 1'b0};
    vecs[3] = '{32'h8000_4000, 32'h8000_5000, 32'd20, 1'b1, 32'hFFFF_FFFF, 2, 16, 4,  0, 1'b0};
    vecs[4] = '{32'h8000_6000, 32'h8000_7000, 32'd4,  1'b0, 32'h8000_6020, 1, 4,  0,  0, 1'b1};
    vecs[5] = '{32'h8000_C000, 32'h8000_D000, 32'd0,  1'b0, 32'hFFFF_FFFF, 0, 0,  0,  0, 1'b0};

    #1;
    chk("reset_ctrl", {arvalid, awvalid, wvalid, wlast, rready, bready, busy_o, done_o, err_o}, 9'd0);
    chk("reset_addr_len", {araddr, awaddr, arlen, awlen}, 80'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      if (i == 5) chk("err_sticky_before_start", err_o, 1'b1);
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset in the middle of the write data phase.
    thr = 1'b1;
    err_addr = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    src_addr_i = 32'h8000_8000; dst_addr_i = 32'h8000_9000; beats_i = 32'd8; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (k = 0; k < 2000; k++) begin
      if (wvalid) break;
      @(posedge clk); #1;
    end
    chk("rst_reached_wr_data", wvalid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_ctrl", {arvalid, awvalid, wvalid, wlast, rready, bready, busy_o, done_o, err_o}, 9'd0);
    chk("rst_mid_addr_len", {araddr, awaddr, arlen, awlen}, 80'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    post = '{32'h8000_A000, 32'h8000_B000, 32'd5, 1'b0, 32'hFFFF_FFFF, 1, 5, 0, 0, 1'b0};
    run_vec("post_reset", post);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
